// File: rtl/slc3_mem_io_responder_if.sv
// MAR/MDR request/response bundle between the SLC-3 datapath (master) and the
// memory/IO responder (slave).
interface slc3_mem_io_responder_if;
    // Handshake: the master raises MEM_REQ with MEM_WE/MAR/MDR and holds it until
    // it sees the one-cycle MEM_READY pulse. The slave samples the request only
    // in IDLE and executes it exactly once. MDR_In and ACCESS_ERR are valid in
    // the MEM_READY cycle, and MDR_In keeps the last read value afterwards.
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic [15:0] MDR_In;
    logic        MEM_READY;
    logic        ACCESS_ERR;

    modport master (
        output MEM_REQ, MEM_WE, MAR, MDR,
        input  MDR_In, MEM_READY, ACCESS_ERR
    );

    modport slave (
        input  MEM_REQ, MEM_WE, MAR, MDR,
        output MDR_In, MEM_READY, ACCESS_ERR
    );
endinterface

// File: rtl/slc3_mem_io_responder.sv
// Program SRAM plus switch/hex I/O word behind the SLC-3 MAR/MDR interface,
// with programmable wait states and a one-cycle completion pulse.
module slc3_mem_io_responder #(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic                   clk,
    input  logic                   reset,
    slc3_mem_io_responder_if.slave bus,
    input  logic [15:0]            SW,
    output logic [15:0]            HEX_OUT,
    output logic [1:0]             dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam int          DEPTH     = 1 << ADDR_W;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [15:0] mdr_in_q, mdr_in_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [15:0] hex_q, hex_d;

    logic        commit;
    logic        is_io;
    logic        is_ram;
    logic        sram_we;
    logic [15:0] sram_rd;
    logic [15:0] sram_q [DEPTH];

    assign is_io   = (addr_q == IO_ADDR);
    assign is_ram  = (addr_q[15:ADDR_W] == '0) && !is_io;
    assign sram_rd = sram_q[addr_q[ADDR_W-1:0]];
    assign sram_we = commit && we_q && is_ram;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        mdr_in_d = mdr_in_q;
        hex_d    = hex_q;
        ready_d  = 1'b0;
        err_d    = 1'b0;
        commit   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.MEM_REQ) begin
                    addr_d  = bus.MAR;
                    wdata_d = bus.MDR;
                    we_d    = bus.MEM_WE;
                    cnt_d   = WAIT_INIT;
                    // A zero count commits on the very next edge, keeping the
                    // commit edge at WAIT_CYCLES+1 for every setting.
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: state_d = S_HOLD;
            S_HOLD: begin
                if (!bus.MEM_REQ) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            ready_d = 1'b1;
            err_d   = !is_io && !is_ram;
            if (we_q) begin
                if (is_io) hex_d = wdata_q;
            end else begin
                mdr_in_d = is_io ? SW : (is_ram ? sram_rd : 16'h0000);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            we_q     <= 1'b0;
            mdr_in_q <= 16'h0000;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            hex_q    <= 16'h0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            mdr_in_q <= mdr_in_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            hex_q    <= hex_d;
        end
    end

    // SRAM contents survive reset; an aborted access never reaches commit.
    always_ff @(posedge clk) begin
        if (sram_we) sram_q[addr_q[ADDR_W-1:0]] <= wdata_q;
    end

    assign bus.MDR_In     = mdr_in_q;
    assign bus.MEM_READY  = ready_q;
    assign bus.ACCESS_ERR = err_q;
    assign HEX_OUT        = hex_q;
    assign dbg_state_o    = state_q;

endmodule
